// File: rtl/hazard_fwd_ctrl_if.sv
// rtl/hazard_fwd_ctrl_if.sv - pipeline-side bundle for the hazard/forwarding controller
interface hazard_fwd_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int NUM_RS = 2,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [NUM_RS*REG_AW-1:0] i_id_rs;
  logic [NUM_RS-1:0]        i_id_rs_used;
  logic [NUM_RS*REG_AW-1:0] i_ex_rs;
  logic [NUM_RS*XLEN-1:0]   i_ex_rs_data;
  logic [REG_AW-1:0]        i_ex_rd;
  logic                     i_ex_we;
  logic                     i_ex_mem_read;
  logic [REG_AW-1:0]        i_mem_rd;
  logic                     i_mem_we;
  logic [XLEN-1:0]          i_mem_alu_out;
  logic [REG_AW-1:0]        i_wb_rd;
  logic                     i_wb_we;
  logic [XLEN-1:0]          i_wb_data;
  logic                     i_branch_taken;
  logic                     i_mem_busy;
  logic [NUM_RS*XLEN-1:0]   o_fwd_data;
  logic [NUM_RS*2-1:0]      o_fwd_sel;
  logic                     o_stall;
  logic                     o_bubble_ex;
  logic                     o_flush_if_id;
  logic                     o_freeze;
  logic [CNT_W-1:0]         o_stall_cnt;
  logic [CNT_W-1:0]         o_flush_cnt;

  // Pipeline side: presents stage state, consumes hazard decisions
  modport master (
    output i_id_rs, i_id_rs_used, i_ex_rs, i_ex_rs_data, i_ex_rd, i_ex_we,
           i_ex_mem_read, i_mem_rd, i_mem_we, i_mem_alu_out, i_wb_rd, i_wb_we,
           i_wb_data, i_branch_taken, i_mem_busy,
    input  o_fwd_data, o_fwd_sel, o_stall, o_bubble_ex, o_flush_if_id, o_freeze,
           o_stall_cnt, o_flush_cnt
  );

  // Controller side
  modport slave (
    input  i_id_rs, i_id_rs_used, i_ex_rs, i_ex_rs_data, i_ex_rd, i_ex_we,
           i_ex_mem_read, i_mem_rd, i_mem_we, i_mem_alu_out, i_wb_rd, i_wb_we,
           i_wb_data, i_branch_taken, i_mem_busy,
    output o_fwd_data, o_fwd_sel, o_stall, o_bubble_ex, o_flush_if_id, o_freeze,
           o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - operand forwarding, load-use stall, branch flush and memory freeze control
module hazard_fwd_ctrl #(
  parameter int XLEN     = 32,
  parameter int NUM_RS   = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input logic              i_clk,
  input logic              i_rst,
  hazard_fwd_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd2;

  localparam logic [2:0] LAT_INIT = 3'(LOAD_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       ret_q, ret_d;
  logic [2:0]       cnt_lat_q, cnt_lat_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             hit;
  logic [1:0]       eff_state;
  logic             stall, bubble, flush;
  logic [NUM_RS*XLEN-1:0] fwd_data;
  logic [NUM_RS*2-1:0]    fwd_sel;

  // Per-port operand bypass: MEM result beats WB result, x0 never forwarded
  always_comb begin
    fwd_sel  = '0;
    fwd_data = bus.i_ex_rs_data;
    for (int p = 0; p < NUM_RS; p++) begin
      if (bus.i_ex_rs[p*REG_AW +: REG_AW] != '0) begin
        if (bus.i_mem_we && bus.i_mem_rd == bus.i_ex_rs[p*REG_AW +: REG_AW]) begin
          fwd_sel[p*2 +: 2]     = 2'd1;
          fwd_data[p*XLEN +: XLEN] = bus.i_mem_alu_out;
        end else if (bus.i_wb_we && bus.i_wb_rd == bus.i_ex_rs[p*REG_AW +: REG_AW]) begin
          fwd_sel[p*2 +: 2]     = 2'd2;
          fwd_data[p*XLEN +: XLEN] = bus.i_wb_data;
        end
      end
    end
  end

  // Load in EX whose destination is read by the instruction sitting in ID
  always_comb begin
    hit = 1'b0;
    for (int p = 0; p < NUM_RS; p++) begin
      if (bus.i_id_rs_used[p] && bus.i_id_rs[p*REG_AW +: REG_AW] == bus.i_ex_rd) begin
        hit = 1'b1;
      end
    end
    hit = hit && bus.i_ex_mem_read && bus.i_ex_we && (bus.i_ex_rd != '0);
  end

  // Hazard FSM: freeze dominates, then taken branch, then load-use stall.
  // MEM_WAIT behaves as the pre-freeze state the cycle busy drops.
  always_comb begin
    eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_lat_d = cnt_lat_q;
    stall     = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    if (bus.i_mem_busy) begin
      state_d = ST_MEM_WAIT;
      ret_d   = eff_state;
    end else if (bus.i_branch_taken) begin
      flush     = 1'b1;
      bubble    = 1'b1;
      state_d   = ST_RUN;
      cnt_lat_d = '0;
    end else if (eff_state == ST_LOAD_STALL) begin
      stall  = 1'b1;
      bubble = 1'b1;
      if (cnt_lat_q <= 3'd1) begin
        state_d   = ST_RUN;
        cnt_lat_d = '0;
      end else begin
        state_d   = ST_LOAD_STALL;
        cnt_lat_d = cnt_lat_q - 3'd1;
      end
    end else begin
      state_d = ST_RUN;
      if (hit) begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (LOAD_LAT > 1) begin
          state_d   = ST_LOAD_STALL;
          cnt_lat_d = LAT_INIT;
        end
      end
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State and counter registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      cnt_lat_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_lat_q   <= cnt_lat_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.o_fwd_data    = fwd_data;
  assign bus.o_fwd_sel     = fwd_sel;
  assign bus.o_stall       = stall;
  assign bus.o_bubble_ex   = bubble;
  assign bus.o_flush_if_id = flush;
  assign bus.o_freeze      = bus.i_mem_busy;
  assign bus.o_stall_cnt   = stall_cnt_q;
  assign bus.o_flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - scoreboard bench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;
  localparam int XLEN = 32;
  localparam int NRS  = 2;
  localparam int RAW  = 5;
  localparam int LAT  = 3;
  localparam int CW   = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.XLEN(XLEN), .NUM_RS(NRS), .REG_AW(RAW), .CNT_W(CW)) hif ();

  hazard_fwd_ctrl #(.XLEN(XLEN), .NUM_RS(NRS), .REG_AW(RAW), .LOAD_LAT(LAT), .CNT_W(CW)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (hif.slave)
  );

  typedef struct {
    logic [NRS*RAW-1:0]  id_rs;
    logic [NRS-1:0]      id_used;
    logic [NRS*RAW-1:0]  ex_rs;
    logic [NRS*XLEN-1:0] ex_data;
    logic [RAW-1:0]      ex_rd;
    logic                ex_we;
    logic                ex_ld;
    logic [RAW-1:0]      mem_rd;
    logic                mem_we;
    logic [XLEN-1:0]     mem_alu;
    logic [RAW-1:0]      wb_rd;
    logic                wb_we;
    logic [XLEN-1:0]     wb_data;
    logic                br;
    logic                busy;
  } stim_t;

  typedef struct {
    logic [NRS*XLEN-1:0] data;
    logic [NRS*2-1:0]    sel;
    logic                stall;
    logic                bubble;
    logic                flush;
    logic                freeze;
    logic [CW-1:0]       scnt;
    logic [CW-1:0]       fcnt;
  } exp_t;

  exp_t expq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // reference model state: stall cycles still owed from an earlier load-use hit
  int owed = 0;
  int m_scnt = 0;
  int m_fcnt = 0;
  localparam int CMAX = (1 << CW) - 1;

  function automatic stim_t zero_s();
    stim_t s;
    s.id_rs = '0; s.id_used = '0; s.ex_rs = '0; s.ex_data = '0;
    s.ex_rd = '0; s.ex_we = 1'b0; s.ex_ld = 1'b0; s.mem_rd = '0; s.mem_we = 1'b0;
    s.mem_alu = '0; s.wb_rd = '0; s.wb_we = 1'b0; s.wb_data = '0;
    s.br = 1'b0; s.busy = 1'b0;
    return s;
  endfunction

  function automatic exp_t predict(input stim_t s, input bit in_reset);
    exp_t e;
    bit   hit;
    int   rs;
    if (in_reset) begin
      owed = 0; m_scnt = 0; m_fcnt = 0;
    end
    // operand source: newest in-flight producer of a nonzero register
    for (int p = 0; p < NRS; p++) begin
      rs = int'(s.ex_rs[p*RAW +: RAW]);
      e.sel[p*2 +: 2] = 2'd0;
      e.data[p*XLEN +: XLEN] = s.ex_data[p*XLEN +: XLEN];
      if (rs != 0 && s.mem_we && int'(s.mem_rd) == rs) begin
        e.sel[p*2 +: 2] = 2'd1; e.data[p*XLEN +: XLEN] = s.mem_alu;
      end else if (rs != 0 && s.wb_we && int'(s.wb_rd) == rs) begin
        e.sel[p*2 +: 2] = 2'd2; e.data[p*XLEN +: XLEN] = s.wb_data;
      end
    end
    hit = 1'b0;
    for (int p = 0; p < NRS; p++)
      if (s.id_used[p] && s.id_rs[p*RAW +: RAW] == s.ex_rd) hit = 1'b1;
    hit = hit && s.ex_ld && s.ex_we && (s.ex_rd != 0);
    e.freeze = s.busy;
    e.stall = 1'b0; e.bubble = 1'b0; e.flush = 1'b0;
    e.scnt = CW'(m_scnt);
    e.fcnt = CW'(m_fcnt);
    if (s.busy) begin
      // everything held
    end else if (s.br) begin
      e.flush = 1'b1; e.bubble = 1'b1;
      if (!in_reset) owed = 0;
    end else if (owed > 0) begin
      e.stall = 1'b1; e.bubble = 1'b1;
      if (!in_reset) owed = owed - 1;
    end else if (hit) begin
      e.stall = 1'b1; e.bubble = 1'b1;
      if (!in_reset) owed = LAT - 1;
    end
    if (!in_reset) begin
      if (e.stall && m_scnt < CMAX) m_scnt++;
      if (e.flush && m_fcnt < CMAX) m_fcnt++;
    end
    return e;
  endfunction

  task automatic apply(input stim_t s, input bit rst_low);
    @(negedge clk);
    rst_n = !rst_low;
    hif.i_id_rs = s.id_rs; hif.i_id_rs_used = s.id_used;
    hif.i_ex_rs = s.ex_rs; hif.i_ex_rs_data = s.ex_data;
    hif.i_ex_rd = s.ex_rd; hif.i_ex_we = s.ex_we; hif.i_ex_mem_read = s.ex_ld;
    hif.i_mem_rd = s.mem_rd; hif.i_mem_we = s.mem_we; hif.i_mem_alu_out = s.mem_alu;
    hif.i_wb_rd = s.wb_rd; hif.i_wb_we = s.wb_we; hif.i_wb_data = s.wb_data;
    hif.i_branch_taken = s.br; hif.i_mem_busy = s.busy;
    expq.push_back(predict(s, rst_low));
  endtask

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, want);
    end
  endfunction

  // monitor: one response per cycle, sampled after inputs settle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_vec++;
        chk("fwd_data",  hif.o_fwd_data,    e.data);
        chk("fwd_sel",   hif.o_fwd_sel,     e.sel);
        chk("stall",     hif.o_stall,       e.stall);
        chk("bubble_ex", hif.o_bubble_ex,   e.bubble);
        chk("flush",     hif.o_flush_if_id, e.flush);
        chk("freeze",    hif.o_freeze,      e.freeze);
        chk("stall_cnt", hif.o_stall_cnt,   e.scnt);
        chk("flush_cnt", hif.o_flush_cnt,   e.fcnt);
      end
    end
  end

  initial begin
    stim_t s, ld, idh;
    hif.i_id_rs = '0; hif.i_id_rs_used = '0; hif.i_ex_rs = '0; hif.i_ex_rs_data = '0;
    hif.i_ex_rd = '0; hif.i_ex_we = 1'b0; hif.i_ex_mem_read = 1'b0;
    hif.i_mem_rd = '0; hif.i_mem_we = 1'b0; hif.i_mem_alu_out = '0;
    hif.i_wb_rd = '0; hif.i_wb_we = 1'b0; hif.i_wb_data = '0;
    hif.i_branch_taken = 1'b0; hif.i_mem_busy = 1'b0;

    // reset state with all inputs quiet
    apply(zero_s(), 1'b1);
    apply(zero_s(), 1'b1);
    apply(zero_s(), 1'b0);

    // forwarding priority, then WB-only
    s = zero_s();
    s.ex_rs[0 +: RAW] = 5'd5; s.ex_data = 64'h0000_3333_0000_4444;
    s.mem_we = 1'b1; s.mem_rd = 5'd5; s.mem_alu = 32'h11;
    s.wb_we = 1'b1; s.wb_rd = 5'd5; s.wb_data = 32'h22;
    apply(s, 1'b0);
    s.mem_we = 1'b0;
    apply(s, 1'b0);

    // x0 guard on forwarding and on load-use
    s = zero_s();
    s.ex_data = 64'h0000_5555_0000_ABCD;
    s.mem_we = 1'b1; s.mem_rd = 5'd0; s.mem_alu = 32'hFF;
    apply(s, 1'b0);
    s = zero_s();
    s.ex_ld = 1'b1; s.ex_we = 1'b1; s.ex_rd = 5'd0; s.id_used = 2'b01;
    apply(s, 1'b0);

    // load-use: load rd=7 in EX, ID reads rs2=7
    ld = zero_s();
    ld.ex_ld = 1'b1; ld.ex_we = 1'b1; ld.ex_rd = 5'd7;
    ld.id_rs[RAW +: RAW] = 5'd7; ld.id_used = 2'b10;
    idh = zero_s();
    idh.id_rs[RAW +: RAW] = 5'd7; idh.id_used = 2'b10;
    apply(ld, 1'b0);
    for (int i = 0; i < 4; i++) apply(idh, 1'b0);

    // taken branch in the second stall cycle
    apply(ld, 1'b0);
    s = idh; s.br = 1'b1;
    apply(s, 1'b0);
    apply(zero_s(), 1'b0);
    apply(zero_s(), 1'b0);

    // memory freeze in LOAD_STALL, then stall resumes
    apply(ld, 1'b0);
    s = idh; s.busy = 1'b1;
    for (int i = 0; i < 4; i++) apply(s, 1'b0);
    for (int i = 0; i < 3; i++) apply(idh, 1'b0);

    // branch held off by freeze, acted on when busy drops
    s = zero_s(); s.br = 1'b1; s.busy = 1'b1;
    apply(s, 1'b0);
    s.busy = 1'b0;
    apply(s, 1'b0);

    // reset mid-LOAD_STALL
    apply(ld, 1'b0);
    apply(zero_s(), 1'b1);
    for (int i = 0; i < 3; i++) apply(zero_s(), 1'b0);

    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      s = zero_s();
      for (int p = 0; p < NRS; p++) begin
        s.id_rs[p*RAW +: RAW] = RAW'($urandom_range(0, 7));
        s.ex_rs[p*RAW +: RAW] = RAW'($urandom_range(0, 7));
        s.ex_data[p*XLEN +: XLEN] = $urandom;
      end
      s.id_used = NRS'($urandom);
      s.ex_rd   = RAW'($urandom_range(0, 7));
      s.ex_we   = ($urandom_range(0, 3) != 0);
      s.ex_ld   = ($urandom_range(0, 2) == 0);
      s.mem_rd  = RAW'($urandom_range(0, 7));
      s.mem_we  = $urandom_range(0, 1) == 1;
      s.mem_alu = $urandom;
      s.wb_rd   = RAW'($urandom_range(0, 7));
      s.wb_we   = $urandom_range(0, 1) == 1;
      s.wb_data = $urandom;
      s.br      = ($urandom_range(0, 7) == 0);
      s.busy    = ($urandom_range(0, 5) == 0);
      apply(s, ($urandom_range(0, 299) == 0));
    end
    apply(zero_s(), 1'b0);

    @(negedge clk);
    #3;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses never checked, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Centralised hazard and forwarding controller for the 5-stage RV pipeline. It is the parametrised successor to the ad-hoc forwarding and load-stall logic in the CPU top. It generalises forwarding to NUM_RS source operands and load-use stalling to a configurable load latency. It adds x0 exclusion, branch-over-stall priority, a memory-wait freeze, and stall/flush performance counters.

Parameters:
XLEN, 32, register/data width
NUM_RS, 2, source operands per instruction (forwarded ports)
REG_AW, 5, register address width
LOAD_LAT, 1, load-use stall cycles (1..7)
CNT_W, 32, performance counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-low
i_id_rs  in  NUM_RS*REG_AW  source regs of instruction in ID (port p at [p*REG_AW +: REG_AW])
i_id_rs_used  in  NUM_RS  operand p actually read by ID instruction
i_ex_rs  in  NUM_RS*REG_AW  source regs of instruction in EX
i_ex_rs_data  in  NUM_RS*XLEN  register-file values latched for EX
i_ex_rd  in  REG_AW  EX destination
i_ex_we  in  1  EX writes rd
i_ex_mem_read  in  1  EX instruction is a load
i_mem_rd  in  REG_AW  MEM-stage destination
i_mem_we  in  1  MEM-stage writes rd
i_mem_alu_out  in  XLEN  MEM-stage ALU result
i_wb_rd  in  REG_AW  WB destination
i_wb_we  in  1  WB writes rd
i_wb_data  in  XLEN  WB write data
i_branch_taken  in  1  EX resolved a taken branch/jump
i_mem_busy  in  1  data memory/peripheral not ready
o_fwd_data  out  NUM_RS*XLEN  forwarded operands to EX
o_fwd_sel  out  NUM_RS*2  per port: 0 regfile, 1 EX/MEM, 2 MEM/WB
o_stall  out  1  hold PC and IF/ID
o_bubble_ex  out  1  load zero into ID/EX
o_flush_if_id  out  1  zero IF/ID
o_freeze  out  1  hold every pipeline register
o_stall_cnt  out  CNT_W  cycles with o_stall=1
o_flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Forwarding is combinational for each port p. If i_ex_rs[p]==0, select 0. Else if i_mem_we && i_mem_rd==rs, select 1 (i_mem_alu_out). Else if i_wb_we && i_wb_rd==rs, select 2 (i_wb_data). Else select 0 (i_ex_rs_data[p]). MEM has priority over WB.
- Load-use hit: i_ex_mem_read && i_ex_we && i_ex_rd!=0 && any p with i_id_rs_used[p] && i_id_rs[p]==i_ex_rd.
- FSM states are RUN, LOAD_STALL and MEM_WAIT. Reset state is RUN, cnt_lat=0, both perf counters 0.
- RUN + hit (no branch, no busy): o_stall=o_bubble_ex=1 this cycle. If LOAD_LAT>1, go to LOAD_STALL with cnt_lat=LOAD_LAT-1.
- LOAD_STALL: o_stall=o_bubble_ex=1 and cnt_lat decrements each cycle. Return to RUN when cnt_lat reaches 1. Total stall is exactly LOAD_LAT cycles per hit.
- Taken branch has priority over load stall. i_branch_taken forces o_flush_if_id=o_bubble_ex=1 and o_stall=0 in the same cycle. It also sends the FSM to RUN with cnt_lat=0.
- i_mem_busy=1 asserts o_freeze combinationally in any state; the next state is MEM_WAIT. While frozen:
  - o_stall, o_bubble_ex and o_flush_if_id are all 0.
  - The branch is not acted on; it is re-presented when the freeze drops.
  - cnt_lat holds.
- On busy deassert, return to the state held before the freeze (RUN or LOAD_STALL) with cnt_lat intact.
- o_stall_cnt increments on each cycle with o_stall=1. o_flush_cnt increments on each cycle with o_flush_if_id=1. Both saturate at all-ones.
- Async reset mid-stall or mid-freeze returns immediately to RUN with counters 0. Outputs are then purely functions of the inputs: with all inputs 0, every output is 0 and o_fwd_data equals i_ex_rs_data.

Test Plan:
- Forwarding priority: EX rs1=5; MEM we rd=5 alu_out=0x11; WB we rd=5 data=0x22 -> o_fwd_sel[0]=1, data 0x11. Drop MEM we -> sel 2, data 0x22.
- x0 guard: rs1=0, MEM we rd=0 alu_out=0xFF -> sel 0, data = regfile value. Load to x0 with ID rs1=0 used -> no stall.
- Load-use with LOAD_LAT=3: EX load rd=7, ID rs2=7 used -> o_stall=o_bubble_ex=1 for exactly 3 cycles, then 0. o_stall_cnt=3.
- Branch during stall (LOAD_LAT=3): i_branch_taken in the 2nd stall cycle -> that cycle o_stall=0, o_flush_if_id=1, o_bubble_ex=1; next cycle RUN, no stall. o_flush_cnt=1.
- Freeze: assert i_mem_busy 4 cycles in LOAD_STALL (cnt_lat=2) -> o_freeze=1 and o_stall=0 for 4 cycles. After release, stall resumes for the remaining 2 cycles.
- Reset mid-LOAD_STALL (i_rst low 1 cycle) -> state RUN, counters 0, o_stall=0 with no hit present.
